// File: rtl/led_status_ctrl.sv
// Multi-channel status LED driver: per-channel off / on / heartbeat / activity-blink modes.
// Activity blinks are stretched to a guaranteed-visible dark+lit pair, with one collapsed follow-on blink.
module led_status_ctrl #(
    parameter int NUM_CH     = 4,
    parameter int CNT_W      = 24,
    parameter int BLINK_HALF = 6250000,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [2*NUM_CH-1:0] mode_i,
    input  logic [NUM_CH-1:0]   act_i,
    output logic [NUM_CH-1:0]   led_o
);

    // A one-cycle blink still needs a 1-bit timer, which then simply stays at zero.
    localparam int              TMR_W    = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(BLINK_HALF - 1);

    localparam logic [1:0] MODE_OFF = 2'd0;
    localparam logic [1:0] MODE_ON  = 2'd1;
    localparam logic [1:0] MODE_HB  = 2'd2;
    localparam logic [1:0] MODE_ACT = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        OFF_PH = 2'd1,
        ON_PH  = 2'd2
    } blink_state_t;

    logic [CNT_W-1:0] cnt;

    // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        blink_state_t     state;
        logic [TMR_W-1:0] timer;
        logic             pending;
        logic             led_q;
        logic [1:0]       mode;
        logic             act;
        logic             raw;

        assign mode     = mode_i[2*i +: 2];
        assign act      = act_i[i];
        assign led_o[i] = led_q;

        always_comb begin
            raw = 1'b0;
            case (mode)
                MODE_OFF: raw = 1'b0;
                MODE_ON:  raw = 1'b1;
                MODE_HB:  raw = cnt[CNT_W-1];
                default:  raw = (state != OFF_PH);
            endcase
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                state   <= IDLE;
                timer   <= '0;
                pending <= 1'b0;
                led_q   <= ACTIVE_LOW;
            end else begin
                led_q <= raw ^ ACTIVE_LOW;
                if (mode != MODE_ACT) begin
                    // Leaving activity mode aborts any blink and drops queued events.
                    state   <= IDLE;
                    timer   <= '0;
                    pending <= 1'b0;
                end else begin
                    case (state)
                        IDLE: begin
                            if (act) begin
                                state <= OFF_PH;
                                timer <= TMR_LOAD;
                            end
                        end
                        OFF_PH: begin
                            if (act) begin
                                pending <= 1'b1;
                            end
                            if (timer == '0) begin
                                state <= ON_PH;
                                timer <= TMR_LOAD;
                            end else begin
                                timer <= timer - TMR_W'(1);
                            end
                        end
                        ON_PH: begin
                            if (timer == '0) begin
                                // An event on the final lit cycle chains straight into the next blink.
                                if (pending || act) begin
                                    state   <= OFF_PH;
                                    timer   <= TMR_LOAD;
                                    pending <= 1'b0;
                                end else begin
                                    state <= IDLE;
                                end
                            end else begin
                                timer <= timer - TMR_W'(1);
                                if (act) begin
                                    pending <= 1'b1;
                                end
                            end
                        end
                        default: begin
                            state   <= IDLE;
                            timer   <= '0;
                            pending <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_led_status_ctrl.sv
// Directed bench for led_status_ctrl: heartbeat sweep plus table-driven activity-blink vectors,
// applied to an active-high and an active-low instance side by side.
module tb_led_status_ctrl;

    localparam int NUM_CH     = 4;
    localparam int CNT_W      = 4;
    localparam int BLINK_HALF = 3;

    // Full led_o patterns with ch1 on, ch0/ch2 off: ch3 lit or dark.
    localparam logic [3:0] LIT  = 4'b1010;
    localparam logic [3:0] DARK = 4'b0010;

    // ch3 activity, ch2 off, ch1 on, ch0 off / ch3 forced on.
    localparam logic [7:0] M_ACT = 8'b11_00_01_00;
    localparam logic [7:0] M_ON  = 8'b01_00_01_00;

    logic                clk = 1'b0;
    logic                rst;
    logic [2*NUM_CH-1:0] mode_i;
    logic [NUM_CH-1:0]   act_i;
    logic [NUM_CH-1:0]   led_hi;
    logic [NUM_CH-1:0]   led_lo;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       rst_v;
        logic [7:0] mode_v;
        logic [3:0] act_v;
        logic [3:0] exp_v;
        string      name;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    led_status_ctrl #(
        .NUM_CH(NUM_CH), .CNT_W(CNT_W), .BLINK_HALF(BLINK_HALF), .ACTIVE_LOW(1'b0)
    ) dut_hi (
        .clk(clk), .rst(rst), .mode_i(mode_i), .act_i(act_i), .led_o(led_hi)
    );

    led_status_ctrl #(
        .NUM_CH(NUM_CH), .CNT_W(CNT_W), .BLINK_HALF(BLINK_HALF), .ACTIVE_LOW(1'b1)
    ) dut_lo (
        .clk(clk), .rst(rst), .mode_i(mode_i), .act_i(act_i), .led_o(led_lo)
    );

    task automatic check(input string name, input logic [3:0] actual, input logic [3:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, actual, expected);
        end
    endtask

    // The active-low instance must always show the bitwise inverse of the active-high expectation.
    task automatic check_both(input string name, input logic [3:0] expected);
        check({name, " hi"}, led_hi, expected);
        check({name, " lo"}, led_lo, ~expected);
    endtask

    task automatic step(input logic r, input logic [7:0] m, input logic [3:0] a);
        rst    = r;
        mode_i = m;
        act_i  = a;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic r, input logic [7:0] m, input logic [3:0] a,
                       input logic [3:0] e, input string n);
        vec_t v;
        v = '{rst_v: r, mode_v: m, act_v: a, exp_v: e, name: n};
        vecs.push_back(v);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst    = 1'b1;
        mode_i = 8'b11_10_01_00;
        act_i  = '0;

        // Reset, then the mixed-mode heartbeat sweep (two full heartbeat periods).
        step(1'b1, 8'b11_10_01_00, 4'h0);
        check_both("reset0", 4'b0000);
        step(1'b1, 8'b11_10_01_00, 4'hF);
        check_both("reset1", 4'b0000);
        for (int k = 1; k <= 32; k++) begin
            logic hb;
            hb = (((k - 1) % 16) >= 8);
            step(1'b0, 8'b11_10_01_00, 4'h0);
            check_both($sformatf("hb k=%0d", k), {1'b1, hb, 1'b1, 1'b0});
        end

        // Single pulse: dark t+1..t+3, lit t+4..t+6, then idle lit.
        add(0, M_ACT, 4'h0, LIT,  "s2 settle");
        add(0, M_ACT, 4'h8, LIT,  "s2 t");
        add(0, M_ACT, 4'h0, DARK, "s2 t+1");
        add(0, M_ACT, 4'h0, DARK, "s2 t+2");
        add(0, M_ACT, 4'h0, DARK, "s2 t+3");
        add(0, M_ACT, 4'h0, LIT,  "s2 t+4");
        add(0, M_ACT, 4'h0, LIT,  "s2 t+5");
        add(0, M_ACT, 4'h0, LIT,  "s2 t+6");
        add(0, M_ACT, 4'h0, LIT,  "s2 t+7");
        add(0, M_ACT, 4'h0, LIT,  "s2 t+8");

        // Pulses at t, t+1, t+4 collapse into exactly one follow-on blink.
        add(0, M_ACT, 4'h8, LIT,  "s3 t");
        add(0, M_ACT, 4'h8, DARK, "s3 t+1");
        add(0, M_ACT, 4'h0, DARK, "s3 t+2");
        add(0, M_ACT, 4'h0, DARK, "s3 t+3");
        add(0, M_ACT, 4'h8, LIT,  "s3 t+4");
        add(0, M_ACT, 4'h0, LIT,  "s3 t+5");
        add(0, M_ACT, 4'h0, LIT,  "s3 t+6");
        add(0, M_ACT, 4'h0, DARK, "s3 t+7");
        add(0, M_ACT, 4'h0, DARK, "s3 t+8");
        add(0, M_ACT, 4'h0, DARK, "s3 t+9");
        add(0, M_ACT, 4'h0, LIT,  "s3 t+10");
        add(0, M_ACT, 4'h0, LIT,  "s3 t+11");
        add(0, M_ACT, 4'h0, LIT,  "s3 t+12");
        add(0, M_ACT, 4'h0, LIT,  "s3 t+13");
        add(0, M_ACT, 4'h0, LIT,  "s3 t+14");

        // Pulse on the last lit cycle chains directly into the next dark phase.
        add(0, M_ACT, 4'h8, LIT,  "s4 t");
        add(0, M_ACT, 4'h0, DARK, "s4 t+1");
        add(0, M_ACT, 4'h0, DARK, "s4 t+2");
        add(0, M_ACT, 4'h0, DARK, "s4 t+3");
        add(0, M_ACT, 4'h0, LIT,  "s4 t+4");
        add(0, M_ACT, 4'h0, LIT,  "s4 t+5");
        add(0, M_ACT, 4'h8, LIT,  "s4 t+6");
        add(0, M_ACT, 4'h0, DARK, "s4 t+7");
        add(0, M_ACT, 4'h0, DARK, "s4 t+8");
        add(0, M_ACT, 4'h0, DARK, "s4 t+9");
        add(0, M_ACT, 4'h0, LIT,  "s4 t+10");
        add(0, M_ACT, 4'h0, LIT,  "s4 t+11");
        add(0, M_ACT, 4'h0, LIT,  "s4 t+12");
        add(0, M_ACT, 4'h0, LIT,  "s4 t+13");

        // Mode forced on mid dark phase aborts the blink; none resumes back in activity mode.
        add(0, M_ACT, 4'h8, LIT,  "s5a t");
        add(0, M_ACT, 4'h0, DARK, "s5a t+1");
        add(0, M_ON,  4'h0, LIT,  "s5a t+2");
        add(0, M_ACT, 4'h0, LIT,  "s5a t+3");
        add(0, M_ACT, 4'h0, LIT,  "s5a t+4");
        add(0, M_ACT, 4'h0, LIT,  "s5a t+5");
        add(0, M_ACT, 4'h0, LIT,  "s5a t+6");

        // Reset mid blink, with act high on the reset edge, leaves every channel idle.
        add(0, M_ACT, 4'h8, LIT,    "s5b t");
        add(0, M_ACT, 4'h0, DARK,   "s5b t+1");
        add(1, M_ACT, 4'h8, 4'h0,   "s5b rst");
        add(0, M_ACT, 4'h0, LIT,    "s5b t+3");
        add(0, M_ACT, 4'h0, LIT,    "s5b t+4");
        add(0, M_ACT, 4'h0, LIT,    "s5b t+5");

        foreach (vecs[n]) begin
            step(vecs[n].rst_v, vecs[n].mode_v, vecs[n].act_v);
            check_both(vecs[n].name, vecs[n].exp_v);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
